// File: rtl/nibble_sum_seq_pkg.sv
// Shared types and constants for the nibble-sum sequencer that drives the data_cal stage.
package nibble_sum_seq_pkg;

  localparam int WORD_W = 16;
  localparam int SUM_W  = 5;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;
  localparam int RES_W  = 3 * SUM_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    S1,
    S2,
    S3,
    DONE
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LOAD = 2'd0;
  localparam logic [SEL_W-1:0] SEL_S1   = 2'd1;
  localparam logic [SEL_W-1:0] SEL_S2   = 2'd2;
  localparam logic [SEL_W-1:0] SEL_S3   = 2'd3;

  function automatic logic [RES_W-1:0] pack_sums(
    input logic [SUM_W-1:0] s3,
    input logic [SUM_W-1:0] s2,
    input logic [SUM_W-1:0] s1
  );
    return {s3, s2, s1};
  endfunction

endpackage

// File: rtl/nibble_sum_seq.sv
// Sequences one accepted word through three data_cal nibble-sum operations and
// presents the packed sums with a valid/ready handshake.
module nibble_sum_seq
  import nibble_sum_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic [WORD_W-1:0]  d,
  output logic [SEL_W-1:0]   sel,
  input  logic [SUM_W-1:0]   cal_out,
  input  logic               cal_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RES_W-1:0]   res_data,
  output logic [CNT_W-1:0]   res_cnt,
  output logic               err
);

  state_t              state;
  state_t              state_next;
  logic [WORD_W-1:0]   word_q;
  logic [SUM_W-1:0]    sum1;
  logic [SUM_W-1:0]    sum2;
  logic [SUM_W-1:0]    sum3;
  logic                accept;
  logic                res_fire;
  logic                in_calc;

  assign in_ready  = (state == IDLE) || ((state == DONE) && res_ready);
  assign res_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign res_fire  = res_valid && res_ready;
  assign in_calc   = (state == S1) || (state == S2) || (state == S3);
  assign d         = word_q;
  assign res_data  = pack_sums(sum3, sum2, sum1);

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sel        = SEL_LOAD;
    case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = S1;
      S1: begin
        sel        = SEL_S1;
        state_next = S2;
      end
      S2: begin
        sel        = SEL_S2;
        state_next = S3;
      end
      S3: begin
        sel        = SEL_S3;
        state_next = DONE;
      end
      DONE: begin
        if (res_ready) state_next = in_valid ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      sum1    <= '0;
      sum2    <= '0;
      sum3    <= '0;
      res_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) word_q <= in_data;
      case (state)
        S1:      sum1 <= cal_out;
        S2:      sum2 <= cal_out;
        S3:      sum3 <= cal_out;
        default: ;
      endcase
      // The sum is still stored when data_cal misses its valid; err flags it.
      if (in_calc && !cal_valid) err <= 1'b1;
      if (res_fire) res_cnt <= res_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_nibble_sum_seq.sv
// Directed bench for nibble_sum_seq with a behavioural data_cal model
// (sum_k = nibble0 + nibble_k).
module tb_nibble_sum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] d;
  logic [1:0]  sel;
  logic [4:0]  cal_out;
  logic        cal_valid;
  logic        res_valid;
  logic        res_ready;
  logic [14:0] res_data;
  logic [7:0]  res_cnt;
  logic        err;
  logic        kill_s2;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  nibble_sum_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .d         (d),
    .sel       (sel),
    .cal_out   (cal_out),
    .cal_valid (cal_valid),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cnt   (res_cnt),
    .err       (err)
  );

  always_comb begin
    cal_out = '0;
    case (sel)
      2'd1:    cal_out = {1'b0, d[3:0]} + {1'b0, d[7:4]};
      2'd2:    cal_out = {1'b0, d[3:0]} + {1'b0, d[11:8]};
      2'd3:    cal_out = {1'b0, d[3:0]} + {1'b0, d[15:12]};
      default: cal_out = '0;
    endcase
    cal_valid = !(kill_s2 && (sel == 2'd2));
  end

  function automatic logic [14:0] mk(input int s3, input int s2, input int s1);
    logic [4:0] a, b, c;
    a = s3[4:0];
    b = s2[4:0];
    c = s1[4:0];
    return {a, b, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at the negedge in DONE.
  task automatic run_word(input logic [15:0] w, input logic [14:0] exp, input bit chk);
    in_valid = 1'b1;
    in_data  = w;
    if (chk) check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (chk) begin
        check("res_valid_early", res_valid, 0);
        check("sel_step", sel, i);
        check("d_step", d, w);
      end
      @(negedge clk);
    end
    if (chk) begin
      check("res_valid_done", res_valid, 1);
      check("res_data", res_data, exp);
    end
  endtask

  task automatic handshake(input bit chk);
    res_ready = 1'b1;
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    if (chk) begin
      check("res_cnt", res_cnt, exp_cnt);
      check("res_valid_after", res_valid, 0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b1;
    kill_s2   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_d", d, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic words and value extremes
    run_word(16'h4321, mk(5, 4, 3), 1);
    handshake(1);
    run_word(16'hFFFF, mk(30, 30, 30), 1);
    handshake(1);
    run_word(16'h0000, mk(0, 0, 0), 1);
    handshake(1);

    // Downstream stall in DONE
    res_ready = 1'b0;
    run_word(16'h1234, mk(5, 6, 7), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_res_valid", res_valid, 1);
      check("stall_res_data", res_data, mk(5, 6, 7));
      check("stall_in_ready", in_ready, 0);
      check("stall_res_cnt", res_cnt, exp_cnt);
    end
    handshake(1);

    // Back-to-back words with in_valid held high
    in_valid = 1'b1;
    in_data  = 16'h1111;
    @(negedge clk);
    in_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      check("b2b_in_ready_busy", in_ready, 0);
      @(negedge clk);
    end
    check("b2b_res_data1", res_data, mk(2, 2, 2));
    check("b2b_in_ready_done", in_ready, 1);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    check("b2b_res_cnt1", res_cnt, exp_cnt);
    check("b2b_res_valid_load", res_valid, 0);
    check("b2b_d_load", d, 16'h2222);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_res_valid_early", res_valid, 0);
    end
    @(negedge clk);
    check("b2b_res_valid2", res_valid, 1);
    check("b2b_res_data2", res_data, mk(4, 4, 4));
    handshake(1);

    // Missing cal_valid in S2 sets a sticky err; the sum is still stored
    kill_s2 = 1'b1;
    run_word(16'h4321, mk(5, 4, 3), 1);
    check("err_set", err, 1);
    handshake(1);
    kill_s2 = 1'b0;
    run_word(16'hFFFF, mk(30, 30, 30), 1);
    handshake(1);
    check("err_sticky", err, 1);

    // Reset in S2 abandons the word
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_sel_s2", sel, 2);
    rst = 1'b1;
    @(negedge clk);
    exp_cnt = 0;
    check("mid_in_ready", in_ready, 1);
    check("mid_res_valid", res_valid, 0);
    check("mid_sel", sel, 0);
    check("mid_d", d, 0);
    check("mid_err", err, 0);
    check("mid_res_cnt", res_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_result", res_valid, 0);
    end
    check("mid_res_cnt_hold", res_cnt, 0);

    // 256 completed results wrap the counter
    for (int k = 0; k < 256; k++) begin
      run_word(16'h0000, mk(0, 0, 0), 0);
      handshake(k >= 254);
    end
    check("wrap_res_cnt", res_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
